// File: rtl/exe_stage.sv
// Execute stage: holds the decode bundle, evaluates the ALU,
// issues data-SRAM requests and forwards results to memory.
// Ports:
//   clk, reset (async active-low)
//   dec_to_exe_valid/bus, exe_allowin : decode-side handshake
//   mem_allowin, exe_to_mem_valid/bus : memory-side handshake
//   gr_we_exe, dest_exe               : hazard info to decode
//   data_sram_*                       : data SRAM request
module exe_stage #(
   parameter int DEC_TO_EXE_BUS_WD = 154,
   parameter int EXE_TO_MEM_BUS_WD = 71
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         dec_to_exe_valid,
   input  logic [DEC_TO_EXE_BUS_WD-1:0] dec_to_exe_bus,
   output logic                         exe_allowin,
   input  logic                         mem_allowin,
   output logic                         exe_to_mem_valid,
   output logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus,
   output logic                         gr_we_exe,
   output logic [4:0]                   dest_exe,
   output logic                         data_sram_en,
   output logic [3:0]                   data_sram_we,
   output logic [31:0]                  data_sram_addr,
   output logic [31:0]                  data_sram_wdata
);

   logic                         valid_q, valid_d;
   logic [DEC_TO_EXE_BUS_WD-1:0] bus_q, bus_d;
   logic                         ready_go;

   logic        inst_ld_w, inst_lu12i_w, inst_st_w;
   logic [11:0] alu_op;
   logic        load_op, src1_is_pc, src2_is_imm, src2_is_4;
   logic        gr_we, mem_we;
   logic [4:0]  dest;
   logic [31:0] imm, rj_value, rkd_value, pc;
   logic [31:0] src1, src2, alu_result;
   logic [4:0]  sh;
   logic        unused_ok;

   assign {inst_ld_w, inst_lu12i_w, inst_st_w, alu_op,
           load_op, src1_is_pc, src2_is_imm, src2_is_4,
           gr_we, mem_we, dest, imm, rj_value,
           rkd_value, pc} = bus_q;

   // Opcode flags are already folded into alu_op/load_op.
   assign unused_ok = ^{inst_ld_w, inst_lu12i_w,
                        inst_st_w, src2_is_4};

   assign ready_go         = 1'b1;
   assign exe_allowin      = !valid_q
                           | (ready_go & mem_allowin);
   assign exe_to_mem_valid = valid_q & ready_go;

   always_comb begin
      valid_d = valid_q;
      bus_d   = bus_q;
      if (exe_allowin) begin
         valid_d = dec_to_exe_valid;
      end
      if (dec_to_exe_valid & exe_allowin) begin
         bus_d = dec_to_exe_bus;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         bus_q   <= '0;
      end else begin
         valid_q <= valid_d;
         bus_q   <= bus_d;
      end
   end

   assign src1 = src1_is_pc  ? pc  : rj_value;
   assign src2 = src2_is_imm ? imm : rkd_value;
   assign sh   = src2[4:0];

   // One-hot select as an OR of gated results.
   always_comb begin
      alu_result = '0;
      if (alu_op[0])
         alu_result = alu_result | (src1 + src2);
      if (alu_op[1])
         alu_result = alu_result | (src1 - src2);
      if (alu_op[2])
         alu_result = alu_result
            | {31'b0, $signed(src1) < $signed(src2)};
      if (alu_op[3])
         alu_result = alu_result | {31'b0, src1 < src2};
      if (alu_op[4])
         alu_result = alu_result | (src1 & src2);
      if (alu_op[5])
         alu_result = alu_result | ~(src1 | src2);
      if (alu_op[6])
         alu_result = alu_result | (src1 | src2);
      if (alu_op[7])
         alu_result = alu_result | (src1 ^ src2);
      if (alu_op[8])
         alu_result = alu_result | (src1 << sh);
      if (alu_op[9])
         alu_result = alu_result | (src1 >> sh);
      if (alu_op[10])
         alu_result = alu_result
            | 32'($signed(src1) >>> sh);
      if (alu_op[11])
         alu_result = alu_result | src2;
   end

   assign gr_we_exe = valid_q & gr_we;
   assign dest_exe  = dest;

   assign exe_to_mem_bus = {load_op, gr_we, dest,
                            alu_result, pc};

   assign data_sram_en    = valid_q & mem_allowin
                          & (load_op | mem_we);
   assign data_sram_we    = {4{valid_q & mem_we
                               & mem_allowin}};
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = rkd_value;

endmodule
